// File: rtl/fetch_sched_mt_pkg.sv
// Shared fetch types and sizing for the multi-threaded fetch scheduler.
// Sizing macros may be overridden on the command line before this file is read.
`ifndef THR_PER_CORE
`define THR_PER_CORE 4
`endif
`ifndef THR_PER_CORE_WIDTH
`define THR_PER_CORE_WIDTH 2
`endif
`ifndef ICACHE_ADDR_WIDTH
`define ICACHE_ADDR_WIDTH 32
`endif
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

package fetch_sched_mt_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int NTHR        = `THR_PER_CORE;
    localparam int TID_W       = `THR_PER_CORE_WIDTH;
    localparam int ADDR_W      = `ICACHE_ADDR_WIDTH;
    localparam int LINE_W      = `ICACHE_LINE_WIDTH;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_W-1:0]      pc;
        logic [TID_W-1:0]       thread_id;
        logic                   valid;
        logic                   xcpt;
    } fetch_out_t;

    // Word 0 of a line occupies the least significant bits.
    function automatic logic [INSTR_WIDTH-1:0] line_word(input logic [LINE_W-1:0] line,
                                                         input logic [1:0] w);
        return line[int'(w)*INSTR_WIDTH +: INSTR_WIDTH];
    endfunction

endpackage

// File: rtl/fetch_sched_mt_rr_arbiter_mt.sv
// Round-robin arbiter: picks the first requester after the last grant.
module rr_arbiter_mt #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] grant_o,
    output logic         valid_o
);

    logic [W-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/fetch_sched_mt.sv
// Multi-threaded instruction fetch scheduler with round-robin thread pick.
// Optional per-thread line buffer enabled by defining FETCH_LINE_BUFFER_EN.
module fetch_sched_mt
    import fetch_sched_mt_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0000_1000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NTHR-1:0]        icache_ready,
    output logic [ADDR_W-1:0]      req_addr,
    output logic                   req_valid,
    output logic [TID_W-1:0]       req_thread_id,
    input  logic [LINE_W-1:0]      rsp_data,
    input  logic                   rsp_valid,
    input  logic                   xcpt_bus_error,
    input  logic [TID_W-1:0]       xcpt_thread_id,
    input  logic                   branch_taken,
    input  logic [TID_W-1:0]       branch_thread_id,
    input  logic [ADDR_W-1:0]      branch_target,
    input  logic                   stall_decode,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_W-1:0]      instr_pc,
    output logic [TID_W-1:0]       instr_thread_id,
    output logic                   xcpt_fetch
);

    logic [ADDR_W-1:0] pc_q [NTHR];
    logic [ADDR_W-1:0] pc_d [NTHR];
    logic [NTHR-1:0]   halted_q, halted_d;
    logic [TID_W-1:0]  last_q, last_d;
    fetch_out_t        out_q, out_d;

    logic [NTHR-1:0]   elig;
    logic [TID_W-1:0]  sel;
    logic              sel_vld;
    logic              fire;
    logic              hit;
    logic              lb_hit;
    logic              xcpt_live;
    logic [LINE_W-1:0] line_data;

    always_comb begin
        elig = '0;
        for (int t = 0; t < NTHR; t++) begin
            elig[t] = icache_ready[t] & ~halted_q[t]
                      & ~(branch_taken & (branch_thread_id == TID_W'(t)));
        end
    end

    rr_arbiter_mt #(.N(NTHR), .W(TID_W)) u_arb (
        .req_i   (elig),
        .last_i  (last_q),
        .grant_o (sel),
        .valid_o (sel_vld)
    );

`ifdef FETCH_LINE_BUFFER_EN
    logic [NTHR-1:0]   lb_vld_q, lb_vld_d;
    logic [ADDR_W-5:0] lb_tag_q  [NTHR];
    logic [ADDR_W-5:0] lb_tag_d  [NTHR];
    logic [LINE_W-1:0] lb_data_q [NTHR];
    logic [LINE_W-1:0] lb_data_d [NTHR];

    assign lb_hit    = lb_vld_q[sel] && (lb_tag_q[sel] == pc_q[sel][ADDR_W-1:4]);
    assign line_data = lb_hit ? lb_data_q[sel] : rsp_data;

    always_comb begin
        lb_vld_d  = lb_vld_q;
        lb_tag_d  = lb_tag_q;
        lb_data_d = lb_data_q;
        if (hit && !lb_hit) begin
            lb_vld_d[sel]  = 1'b1;
            lb_tag_d[sel]  = pc_q[sel][ADDR_W-1:4];
            lb_data_d[sel] = rsp_data;
        end
        if (xcpt_live) lb_vld_d[xcpt_thread_id] = 1'b0;
        if (branch_taken) lb_vld_d[branch_thread_id] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lb_vld_q <= '0;
            for (int t = 0; t < NTHR; t++) begin
                lb_tag_q[t]  <= '0;
                lb_data_q[t] <= '0;
            end
        end else begin
            lb_vld_q  <= lb_vld_d;
            lb_tag_q  <= lb_tag_d;
            lb_data_q <= lb_data_d;
        end
    end
`else
    assign lb_hit    = 1'b0;
    assign line_data = rsp_data;
`endif

    assign fire          = sel_vld & ~stall_decode & ~reset;
    assign req_valid     = fire & ~lb_hit;
    assign req_addr      = pc_q[sel];
    assign req_thread_id = sel;
    assign hit           = fire & (lb_hit | rsp_valid);
    // A redirect of the faulting thread wins over its bus error.
    assign xcpt_live     = xcpt_bus_error
                           & ~(branch_taken & (branch_thread_id == xcpt_thread_id));

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        last_d   = last_q;
        out_d    = out_q;

        if (fire) last_d = sel;

        if (!stall_decode) begin
            out_d = '0;
            if (hit) begin
                out_d.valid     = 1'b1;
                out_d.instr     = line_word(line_data, pc_q[sel][3:2]);
                out_d.pc        = pc_q[sel];
                out_d.thread_id = sel;
            end
        end

        if (hit && !xcpt_live) pc_d[sel] = pc_q[sel] + ADDR_W'(4);

        if (xcpt_live) begin
            halted_d[xcpt_thread_id] = 1'b1;
            out_d           = '0;
            out_d.xcpt      = 1'b1;
            out_d.pc        = pc_q[xcpt_thread_id];
            out_d.thread_id = xcpt_thread_id;
        end

        if (branch_taken) begin
            pc_d[branch_thread_id]     = {branch_target[ADDR_W-1:2], 2'b00};
            halted_d[branch_thread_id] = 1'b0;
            // Only a held instruction can belong to the redirected thread.
            if (out_d.valid && (out_d.thread_id == branch_thread_id)) out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NTHR; t++) pc_q[t] <= BOOT_ADDR;
            halted_q <= '0;
            last_q   <= TID_W'(NTHR - 1);
            out_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            last_q   <= last_d;
            out_q    <= out_d;
        end
    end

    assign instr_valid     = out_q.valid;
    assign instr           = out_q.instr;
    assign instr_pc        = out_q.pc;
    assign instr_thread_id = out_q.thread_id;
    assign xcpt_fetch      = out_q.xcpt;

endmodule
